// File: rtl/seq_multiplier.sv
// Radix-2 shift-add N x M multiplier, one multiplier bit per clock, with valid/ready on both sides.
// Optional: define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [M-1:0]     B,
  input  logic             SGN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   P,
  output logic             busy
);

  localparam int W  = N + M;
  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [W-1:0]  a_q, a_d;
  logic signed [W-1:0]  acc_q, acc_d;
  logic [M-1:0]         b_q, b_d;
  logic                 sgn_q, sgn_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         p_q, p_d;
  logic                 last;
  logic signed [W-1:0]  addend;

  function automatic logic signed [W-1:0] ext_a(input logic [N-1:0] a, input logic s);
    ext_a = {{M{s & a[N-1]}}, a};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // a_q holds ext(A) << k and b_q holds B >> k, so bit 0 of b_q is the current multiplier bit.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    acc_d    = acc_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    last     = (cnt_q == CW'(M - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
    last     = last || (b_q[M-1:1] == '0);
`else
`endif
    addend   = b_q[0] ? a_q : '0;

    case (state_q)
      BUSY: begin
        // The MSB of a signed multiplier carries negative weight.
        if (sgn_q && (cnt_q == CW'(M - 1))) acc_d = acc_q - addend;
        else                                acc_d = acc_q + addend;
        a_d   = a_q <<< 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          p_d     = acc_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (in_valid && in_ready) begin
      state_d = BUSY;
      a_d     = ext_a(A, SGN);
      b_d     = B;
      sgn_d   = SGN;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a 4x4 instance for the main vectors and a 6x3 instance for the odd-width signed case.
module tb_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0, SGN = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] P;

  logic       in_valid6 = 1'b0, out_ready6 = 1'b0, SGN6 = 1'b0;
  logic [5:0] A6 = '0;
  logic [2:0] B6 = '0;
  logic       in_ready6, out_valid6, busy6;
  logic [8:0] P6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.N(4), .M(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .SGN(SGN), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .busy(busy)
  );

  seq_multiplier #(.N(6), .M(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .A(A6), .B(B6), .SGN(SGN6), .out_valid(out_valid6), .out_ready(out_ready6),
    .P(P6), .busy(busy6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b, input int m);
    int l;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < m; i++) if (b[i]) l = i + 1;
`else
    l = m;
`endif
    return l;
  endfunction

  // Waits from just after the accepting edge until out_valid, returning the edge count.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic [7:0] exp_p);
    int lat;
    @(negedge clk);
    A = a; B = b; SGN = s; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; A = 4'h0; B = 4'h0; SGN = ~s;
    check({tag, "_busy"}, busy, 1);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat(b, 4));
    check({tag, "_P"}, P, exp_p);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retired"}, out_valid, 0);
    check({tag, "_P_held"}, P, exp_p);
  endtask

  initial begin
    int lat;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_P", P, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    run_op("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
    run_op("s_m8x7", 4'h8, 4'h7, 1'b1, 8'hC8);
    run_op("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
    run_op("s_m1xm1", 4'hF, 4'hF, 1'b1, 8'h01);
    run_op("u5x1", 4'h5, 4'h1, 1'b0, 8'h05);
    run_op("u0x5", 4'h0, 4'h5, 1'b0, 8'h00);
    run_op("u9x3", 4'h9, 4'h3, 1'b0, 8'h1B);
    run_op("s7x0", 4'h7, 4'h0, 1'b1, 8'h00);

    // Backpressure, then simultaneous retire and accept.
    @(negedge clk);
    A = 4'hF; B = 4'hF; SGN = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    A = 4'h3; B = 4'h5;
    wait_done(lat);
    check("bp_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_P", P, 8'hE1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_accept_busy", busy, 1);
    check("bp_accept_out_valid", out_valid, 0);
    check("bp_accept_P_old", P, 8'hE1);
    wait_done(lat);
    check("bp_next_lat", lat, exp_lat(32'd5, 4));
    check("bp_next_P", P, 8'h0F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset two cycles into an operation.
    @(negedge clk);
    A = 4'h9; B = 4'hF; SGN = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_P", P, 0);
    check("mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("mid_no_pulse", lat, 0);
    run_op("u6x6", 4'h6, 4'h6, 1'b0, 8'd36);

    // Odd-width signed case on the 6x3 instance.
    @(negedge clk);
    A6 = 6'h21; B6 = 3'b011; SGN6 = 1'b1; in_valid6 = 1'b1;
    @(posedge clk); #1;
    in_valid6 = 1'b0; A6 = '0; B6 = '0;
    lat = 0;
    while (!out_valid6 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("n6m3_lat", lat, exp_lat(32'd3, 3));
    check("n6m3_P", P6, 9'h1A3);
    check("n6m3_busy", busy6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
